dma_fifo_bridge: RTL
====================

Name: dma_fifo_bridge

Overview:
- Dual byte-wide synchronous FIFO pair between the external data source/sink (USB/UART front end) and the memory DMA engine's FIFO bus.
- RX path: the front end pushes bytes in; the DMA engine pops them, with a 1-cycle registered read latency.
- TX path: the DMA engine pushes bytes in; the front end pops them.
- Each direction has independent occupancy tracking and a synchronous flush.

Parameters:
- RX_DEPTH_LOG2, 10, RX FIFO depth = 2**RX_DEPTH_LOG2 bytes.
- TX_DEPTH_LOG2, 10, TX FIFO depth = 2**TX_DEPTH_LOG2 bytes.

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- rx_flush  in  1  clear RX FIFO
- tx_flush  in  1  clear TX FIFO
- rx_in_write  in  1  front end pushes rx_in_data
- rx_in_data  in  8  RX byte in
- rx_in_full  out  1  RX FIFO full
- rx_read  in  1  DMA pops RX byte
- rx_empty  out  1  RX FIFO empty
- rx_rdata  out  8  popped RX byte, valid cycle after rx_read
- rx_count  out  RX_DEPTH_LOG2+1  RX occupancy
- tx_write  in  1  DMA pushes tx_wdata
- tx_wdata  in  8  TX byte in
- tx_full  out  1  TX FIFO full
- tx_out_read  in  1  front end pops TX byte
- tx_out_empty  out  1  TX FIFO empty
- tx_out_data  out  8  popped TX byte, valid cycle after tx_out_read
- tx_count  out  TX_DEPTH_LOG2+1  TX occupancy

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Each FIFO holds the following registers:
  - wptr and rptr, DEPTH_LOG2 bits each, wrapping modulo depth.
  - count, DEPTH_LOG2+1 bits.
  - a registered output byte.
  - storage that infers block RAM with a registered read.
- Flags are combinational from the count register only:
  - empty = (count == 0)
  - full = (count == 2**DEPTH_LOG2)
  - Flags never depend combinationally on the same-cycle write/read inputs.
- Push is accepted when write && !full at the edge:
  - the byte is stored at wptr;
  - wptr increments.
- Push while full is ignored: data dropped, pointers and count unchanged.
- Pop is accepted when read && !empty at the edge:
  - the output byte register loads mem[rptr];
  - rptr increments;
  - the byte is valid on rx_rdata / tx_out_data from the cycle after the pop until the next accepted pop.
- Pop while empty is ignored; the output byte holds its previous value.
- Count update per edge:
  - +1 on an accepted push only;
  - -1 on an accepted pop only;
  - unchanged when both push and pop are accepted in the same cycle.
- Simultaneous push and pop on a non-empty, non-full FIFO are both accepted.
  - With count==0, the pop is rejected and the push accepted; the new byte is poppable starting the next cycle (write-to-pop latency 1 cycle).
  - With count==full, the push is rejected and the pop accepted.
- Back-to-back pops every cycle are sustained at 1 byte/cycle. The DMA engine may assert rx_read on consecutive cycles while !rx_empty.
- Pointer wrap-around (depth-1 -> 0) is seamless. Ordering is strict FIFO across the wrap.
- Flush (rx_flush / tx_flush):
  - sets wptr=rptr=count=0 on that FIFO at the edge;
  - any push or pop in the same cycle is discarded;
  - the output byte register is unchanged;
  - the other direction is unaffected.
- Reset values:
  - all pointers and counts 0;
  - rx_empty=1, tx_out_empty=1;
  - rx_in_full=0, tx_full=0;
  - rx_rdata=8'h00, tx_out_data=8'h00.
- Reset mid-operation drops all buffered data in both directions. Reset has priority over flush, push and pop.
- Storage contents are not reset.

Optional Feature:
Macro: DMA_FIFO_BRIDGE_ERROR_FLAGS_EN
- With the macro defined:
  - Adds four outputs: rx_overflow, rx_underflow, tx_overflow, tx_underflow (1 bit each).
  - Overflow sets on a push attempted while full.
  - Underflow sets on a pop attempted while empty.
  - Flags are sticky; they clear on reset or on the flush of the same direction.
  - A flush has priority over a set in the same cycle.
  - Reset value of all four flags is 0.
- Without the macro: the ports and logic are absent; ignored pushes and pops are silent.

Test Plan:
1. Reset, then push 3 RX bytes 0x11, 0x22, 0x33 on consecutive cycles.
   - rx_count goes 1, 2, 3.
   - Then rx_read for 3 consecutive cycles: rx_rdata shows 0x11, 0x22, 0x33 on the cycles after each read.
   - rx_empty=1 and rx_count=0 after the third pop.
2. Fill TX (RX_DEPTH_LOG2=TX_DEPTH_LOG2=2, depth 4) with 0xA0..0xA3, then push 0xFF while full.
   - tx_full=1, tx_count=4, 0xFF dropped.
   - Pops return 0xA0..0xA3.
   - tx_out_data holds 0xA3 after a pop attempted while empty.
3. Depth 4, 10 push+pop pairs interleaved with count hovering 1..3 (pointer wrap twice).
   - The output sequence equals the input sequence 0x00..0x09.
4. Count==2, assert push and pop in the same cycle -> count stays 2, both accepted.
   - Count==0, assert both -> push accepted, pop rejected, count=1, output byte unchanged.
5. RX holds 3 bytes, TX holds 2.
   - Pulse rx_flush -> rx_count=0, rx_empty=1; tx_count stays 2.
   - A push in the flush cycle is discarded.
6. Macro defined:
   - pop on empty RX -> rx_underflow=1 and stays 1;
   - push to full TX -> tx_overflow=1;
   - rx_flush clears only rx_underflow;
   - reset clears all four flags.

Source files
------------

// File: rtl/dma_fifo_bridge_if.sv
// Byte-wide FIFO bus between the front end / DMA engine and dma_fifo_bridge.
// Error flag signals exist only when DMA_FIFO_BRIDGE_ERROR_FLAGS_EN is defined.
interface dma_fifo_bridge_if #(
    parameter int RX_DEPTH_LOG2 = 10,
    parameter int TX_DEPTH_LOG2 = 10
);
    logic                   rx_flush;
    logic                   tx_flush;
    logic                   rx_in_write;
    logic [7:0]             rx_in_data;
    logic                   rx_in_full;
    logic                   rx_read;
    logic                   rx_empty;
    logic [7:0]             rx_rdata;
    logic [RX_DEPTH_LOG2:0] rx_count;
    logic                   tx_write;
    logic [7:0]             tx_wdata;
    logic                   tx_full;
    logic                   tx_out_read;
    logic                   tx_out_empty;
    logic [7:0]             tx_out_data;
    logic [TX_DEPTH_LOG2:0] tx_count;
`ifdef DMA_FIFO_BRIDGE_ERROR_FLAGS_EN
    logic                   rx_overflow;
    logic                   rx_underflow;
    logic                   tx_overflow;
    logic                   tx_underflow;
`endif

    modport slave (
`ifdef DMA_FIFO_BRIDGE_ERROR_FLAGS_EN
        output rx_overflow, rx_underflow, tx_overflow, tx_underflow,
`endif
        input  rx_flush, tx_flush, rx_in_write, rx_in_data, rx_read,
        input  tx_write, tx_wdata, tx_out_read,
        output rx_in_full, rx_empty, rx_rdata, rx_count,
        output tx_full, tx_out_empty, tx_out_data, tx_count
    );

    modport master (
`ifdef DMA_FIFO_BRIDGE_ERROR_FLAGS_EN
        input  rx_overflow, rx_underflow, tx_overflow, tx_underflow,
`endif
        output rx_flush, tx_flush, rx_in_write, rx_in_data, rx_read,
        output tx_write, tx_wdata, tx_out_read,
        input  rx_in_full, rx_empty, rx_rdata, rx_count,
        input  tx_full, tx_out_empty, tx_out_data, tx_count
    );
endinterface

// File: rtl/dma_fifo_bridge.sv
// RX/TX byte FIFO pair bridging the front end and the DMA FIFO bus.
// Define DMA_FIFO_BRIDGE_ERROR_FLAGS_EN to add sticky overflow/underflow flags.
module dma_fifo_bridge_fifo #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                write,
    input  logic [7:0]          wdata,
    input  logic                read,
`ifdef DMA_FIFO_BRIDGE_ERROR_FLAGS_EN
    output logic                overflow,
    output logic                underflow,
`endif
    output logic                full,
    output logic                empty,
    output logic [7:0]          rdata,
    output logic [DEPTH_LOG2:0] count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [7:0]            rdata_q, rdata_d;
    logic                  push, pop;

    // Flags come only from the registered count, never from this cycle's strobes.
    assign empty = (count_q == '0);
    assign full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign rdata = rdata_q;
    assign count = count_q;

    assign push = write && !full && !flush && !reset;
    assign pop  = read && !empty && !flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        rdata_d = rdata_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop) begin
                rptr_d  = rptr_q + 1'b1;
                rdata_d = mem[rptr_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef DMA_FIFO_BRIDGE_ERROR_FLAGS_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (write && full)  overflow_d  = 1'b1;
            if (read && empty)  underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif
endmodule

module dma_fifo_bridge #(
    parameter int RX_DEPTH_LOG2 = 10,
    parameter int TX_DEPTH_LOG2 = 10
) (
    input  logic           clk,
    input  logic           reset,
    dma_fifo_bridge_if.slave bus
);
    dma_fifo_bridge_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.rx_flush),
        .write     (bus.rx_in_write),
        .wdata     (bus.rx_in_data),
        .read      (bus.rx_read),
`ifdef DMA_FIFO_BRIDGE_ERROR_FLAGS_EN
        .overflow  (bus.rx_overflow),
        .underflow (bus.rx_underflow),
`endif
        .full      (bus.rx_in_full),
        .empty     (bus.rx_empty),
        .rdata     (bus.rx_rdata),
        .count     (bus.rx_count)
    );

    dma_fifo_bridge_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.tx_flush),
        .write     (bus.tx_write),
        .wdata     (bus.tx_wdata),
        .read      (bus.tx_out_read),
`ifdef DMA_FIFO_BRIDGE_ERROR_FLAGS_EN
        .overflow  (bus.tx_overflow),
        .underflow (bus.tx_underflow),
`endif
        .full      (bus.tx_full),
        .empty     (bus.tx_out_empty),
        .rdata     (bus.tx_out_data),
        .count     (bus.tx_count)
    );
endmodule
